posit_encode_pipe: RTL and testbench

POSIT_ENCODE_PIPE -- requirements
Module: posit_encode_pipe

---
 rtl/posit_encode_pipe.sv | 177 +++++++++++++++++
 tb/tb_posit_encode_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/posit_encode_pipe.sv
// posit_encode_pipe: 3-stage posit encoder.
// Takes an unpacked value (sign, scale, fraction, sticky, zero/NaR flags),
// builds the regime/exponent/fraction bit string, rounds to nearest even
// and returns the two's-complement posit with a matching done strobe.
module posit_encode_pipe #(
    parameter int N  = 32,
    parameter int es = 2,
    parameter int Bs = $clog2(N),
    parameter int SW = es + Bs + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          sign,
    input  logic          zero,
    input  logic          nar,
    input  logic [SW-1:0] scale,
    input  logic [N-1:0]  frac,
    input  logic          sticky,
    output logic [N-1:0]  out,
    output logic          done
);

    // Widest scale still encodable: regime of N-1 bits.
    localparam logic signed [SW-1:0] SMAX = SW'((N - 2) * (1 << es));
    localparam logic signed [SW-1:0] SMIN = -SMAX;
    // {terminator, e, frac, sticky}, padded below so no shifted bit is lost.
    localparam int AW = es + N + 2;
    localparam int WW = AW + N;

    // valid chain
    logic s1, s2, s3;

    // operand registers
    logic          in_sign, in_zero, in_nar, in_sticky;
    logic [SW-1:0] in_scale;
    logic [N-1:0]  in_frac;

    // stage 1 registers
    logic          p1_sign, p1_zero, p1_nar, p1_sticky, p1_r;
    logic [SW-1:0] p1_sh;
    logic [es-1:0] p1_e;
    logic [N-1:0]  p1_frac;

    // stage 2 registers
    logic          p2_sign, p2_zero, p2_nar, p2_g, p2_st;
    logic [N-2:0]  p2_mag;

    // stage 1 combinational
    logic signed [SW-1:0] sc, sc_c, k;
    logic [SW-1:0]        sh_c;

    // stage 2 combinational
    logic [AW-1:0] arr;
    logic [WW-1:0] wide, shifted;

    // stage 3 combinational
    logic [N-1:0]  sum;
    logic [N-2:0]  mag_r;
    logic [N-1:0]  out_c;
    logic          ulp;

    // Start-valid shift chain; done follows the last stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            done <= 1'b0;
        end else begin
            s1   <= start;
            s2   <= s1;
            s3   <= s2;
            done <= s3;
        end
    end

    // Operand capture, held while start is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_sign   <= 1'b0;
            in_zero   <= 1'b0;
            in_nar    <= 1'b0;
            in_sticky <= 1'b0;
            in_scale  <= '0;
            in_frac   <= '0;
        end else if (start) begin
            in_sign   <= sign;
            in_zero   <= zero;
            in_nar    <= nar;
            in_sticky <= sticky;
            in_scale  <= scale;
            in_frac   <= frac;
        end
    end

    // Stage 1: clamp scale, split into regime value k and exponent e.
    always_comb begin
        sc = $signed(in_scale);
        if (sc > SMAX)      sc_c = SMAX;
        else if (sc < SMIN) sc_c = SMIN;
        else                sc_c = sc;
        k = sc_c >>> es;
        // Run length before the terminator: k+1 ones, or -k zeros.
        sh_c = k[SW-1] ? (~k + SW'(1)) : (k + SW'(1));
    end

    // Stage 1 registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_sign   <= 1'b0;
            p1_zero   <= 1'b0;
            p1_nar    <= 1'b0;
            p1_sticky <= 1'b0;
            p1_r      <= 1'b0;
            p1_sh     <= '0;
            p1_e      <= '0;
            p1_frac   <= '0;
        end else begin
            p1_sign   <= in_sign;
            p1_zero   <= in_zero;
            p1_nar    <= in_nar;
            p1_sticky <= in_sticky;
            p1_r      <= ~k[SW-1];
            p1_sh     <= sh_c;
            p1_e      <= sc_c[es-1:0];
            p1_frac   <= in_frac;
        end
    end

    // Stage 2: the regime is produced by shifting the terminator-led array
    // right and filling the vacated top bits with the run bit.
    always_comb begin
        arr     = {~p1_r, p1_e, p1_frac, p1_sticky};
        wide    = {arr, {N{1'b0}}};
        shifted = (wide >> p1_sh) | (p1_r ? ~({WW{1'b1}} >> p1_sh) : '0);
    end

    // Stage 2 registers: kept magnitude, guard, and sticky of the rest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p2_sign <= 1'b0;
            p2_zero <= 1'b0;
            p2_nar  <= 1'b0;
            p2_g    <= 1'b0;
            p2_st   <= 1'b0;
            p2_mag  <= '0;
        end else begin
            p2_sign <= p1_sign;
            p2_zero <= p1_zero;
            p2_nar  <= p1_nar;
            p2_mag  <= shifted[WW-1 -: N-1];
            p2_g    <= shifted[WW-N];
            p2_st   <= |shifted[WW-N-1:0];
        end
    end

    // Stage 3: round to nearest even, saturate, apply sign and specials.
    always_comb begin
        ulp = p2_g & (p2_st | p2_mag[0]);
        sum = {1'b0, p2_mag} + {{(N-1){1'b0}}, ulp};
        if (sum[N-1])      mag_r = '1;
        else if (sum == '0) mag_r = {{(N-2){1'b0}}, 1'b1};
        else               mag_r = sum[N-2:0];
        if (p2_nar)        out_c = {1'b1, {(N-1){1'b0}}};
        else if (p2_zero)  out_c = '0;
        else if (p2_sign)  out_c = -{1'b0, mag_r};
        else               out_c = {1'b0, mag_r};
    end

    // Output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) out <= '0;
        else          out <= out_c;
    end

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed-vector bench for posit_encode_pipe at N=32, es=2.
module tb_posit_encode_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start, sign, zero, nar, sticky;
    logic [7:0]  scale;
    logic [31:0] frac;
    logic [31:0] out;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        s, z, n;
        logic [7:0]  sc;
        logic [31:0] fr;
        logic        st;
        logic [31:0] exp;
    } vec_t;

    posit_encode_pipe #(.N(32), .es(2)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .sign(sign),
        .zero(zero), .nar(nar), .scale(scale), .frac(frac),
        .sticky(sticky), .out(out), .done(done)
    );

    always #5 clock = ~clock;

    // Drives one operation; returns done seen one edge early, done at the
    // expected edge, and out at that edge.
    task automatic run_op(input vec_t v, output logic early, output logic dn,
                          output logic [31:0] res);
        @(negedge clock);
        sign = v.s; zero = v.z; nar = v.n; scale = v.sc; frac = v.fr;
        sticky = v.st; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        early = done;
        @(negedge clock);
        dn  = done;
        res = out;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (out !== 32'h0) begin
            n_err++; $display("FAIL reset_out: got %h want %h", out, 32'h0);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", done);
        end
    endtask

    task automatic test_vectors(input string name, input vec_t tbl[]);
        logic early, dn;
        logic [31:0] res;
        foreach (tbl[i]) begin
            run_op(tbl[i], early, dn, res);
            n_cmp++;
            if (early !== 1'b0 || dn !== 1'b1) begin
                n_err++;
                $display("FAIL %s[%0d]_latency: got early=%b done=%b want early=0 done=1",
                         name, i, early, dn);
            end
            n_cmp++;
            if (res !== tbl[i].exp) begin
                n_err++;
                $display("FAIL %s[%0d]_out: got %h want %h", name, i, res, tbl[i].exp);
            end
        end
    endtask

    task automatic test_unit;
        vec_t t[] = '{
            '{1'b0, 1'b0, 1'b0, 8'd0,   32'h0, 1'b0, 32'h40000000},
            '{1'b1, 1'b0, 1'b0, 8'd0,   32'h0, 1'b0, 32'hC0000000},
            '{1'b0, 1'b0, 1'b0, 8'd1,   32'h0, 1'b0, 32'h48000000},
            '{1'b0, 1'b0, 1'b0, 8'hFF,  32'h0, 1'b0, 32'h38000000},
            '{1'b0, 1'b0, 1'b0, 8'd4,   32'h0, 1'b0, 32'h60000000}
        };
        test_vectors("unit", t);
    endtask

    task automatic test_rounding;
        vec_t t[] = '{
            '{1'b0, 1'b0, 1'b0, 8'd0, 32'h00000018, 1'b0, 32'h40000001},
            '{1'b0, 1'b0, 1'b0, 8'd0, 32'h00000010, 1'b0, 32'h40000000},
            '{1'b0, 1'b0, 1'b0, 8'd0, 32'h00000010, 1'b1, 32'h40000001},
            '{1'b0, 1'b0, 1'b0, 8'd0, 32'h00000030, 1'b0, 32'h40000002}
        };
        test_vectors("round", t);
    endtask

    // 8-bit scale cannot hold +/-200; +127 and -128 are the largest
    // representable values outside the [-120, 120] encodable range.
    task automatic test_saturation;
        vec_t t[] = '{
            '{1'b0, 1'b0, 1'b0, 8'd127, 32'h0,        1'b0, 32'h7FFFFFFF},
            '{1'b0, 1'b0, 1'b0, 8'h80,  32'h0,        1'b0, 32'h00000001},
            '{1'b1, 1'b0, 1'b0, 8'h80,  32'h0,        1'b0, 32'hFFFFFFFF},
            '{1'b0, 1'b0, 1'b0, 8'd120, 32'hFFFFFFFF, 1'b1, 32'h7FFFFFFF}
        };
        test_vectors("sat", t);
    endtask

    task automatic test_specials;
        vec_t t[] = '{
            '{1'b0, 1'b1, 1'b0, 8'd5, 32'h12345678, 1'b1, 32'h00000000},
            '{1'b1, 1'b1, 1'b0, 8'd5, 32'h12345678, 1'b0, 32'h00000000},
            '{1'b0, 1'b1, 1'b1, 8'd0, 32'h0,        1'b0, 32'h80000000},
            '{1'b1, 1'b0, 1'b1, 8'd3, 32'hABCDEF01, 1'b1, 32'h80000000}
        };
        test_vectors("special", t);
    endtask

    task automatic test_back_to_back;
        vec_t t[5] = '{
            '{1'b0, 1'b0, 1'b0, 8'd0,  32'h0,        1'b0, 32'h40000000},
            '{1'b1, 1'b0, 1'b0, 8'd0,  32'h0,        1'b0, 32'hC0000000},
            '{1'b0, 1'b0, 1'b0, 8'd1,  32'h0,        1'b0, 32'h48000000},
            '{1'b0, 1'b0, 1'b0, 8'd0,  32'h00000018, 1'b0, 32'h40000001},
            '{1'b0, 1'b0, 1'b0, 8'hFF, 32'h0,        1'b0, 32'h38000000}
        };
        logic want;
        // Negedge c observes edges up to c-1; op i sampled at edge i.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            want = (c >= 4 && c <= 8);
            n_cmp++;
            if (done !== want) begin
                n_err++; $display("FAIL stream_done[%0d]: got %b want %b", c, done, want);
            end
            if (want) begin
                n_cmp++;
                if (out !== t[c-4].exp) begin
                    n_err++;
                    $display("FAIL stream_out[%0d]: got %h want %h", c - 4, out, t[c-4].exp);
                end
            end
            if (c < 5) begin
                sign = t[c].s; zero = t[c].z; nar = t[c].n; scale = t[c].sc;
                frac = t[c].fr; sticky = t[c].st; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clock);
        sign = 1'b1; zero = 1'b0; nar = 1'b0; scale = 8'd1; frac = 32'h0;
        sticky = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out !== 32'h0) begin
            n_err++; $display("FAIL midrst_out: got %h want %h", out, 32'h0);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL midrst_done: got %b want 0", done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++; $display("FAIL midrst_ghost[%0d]: got done=%b want 0", c, done);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; sign = 1'b0; zero = 1'b0; nar = 1'b0;
        scale = '0; frac = '0; sticky = 1'b0;
        #2;
        test_reset;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        test_unit;
        test_rounding;
        test_saturation;
        test_specials;
        test_back_to_back;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
